// File: rtl/axi_master_arbiter_pkg.sv
// axi_master_arbiter_pkg: shared FSM encoding and width helpers for the arbiter slice
package axi_master_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic int strb_w(int dw);
    return dw / 8;
  endfunction
  function automatic int cnt_w(int t);
    return $clog2(t);
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_master_arbiter_rr_arbiter.sv
// axi_master_arbiter_rr_arbiter: combinational round-robin pick of the first request at/after ptr
module axi_master_arbiter_rr_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] gnt
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      idx = req[j] ? j : idx;
    end
  end
  assign any = |req;
  assign gnt = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: round-robin sharing of one axi_master user port, one transaction in flight
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 256,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*STRB_W-1:0]   req_wstrb,
  output logic [NREQ-1:0]          req_gnt,
  output logic [NREQ-1:0]          req_done,
  output logic                     req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     m_valid,
  output logic                     m_valid_r,
  output logic [ADDR_W-1:0]        m_aw_addr,
  output logic [ADDR_W-1:0]        m_ar_addr,
  output logic [DATA_W-1:0]        m_w_data,
  output logic [STRB_W-1:0]        m_w_strb,
  input  logic                     m_ready,
  input  logic                     m_r_done,
  input  logic [DATA_W-1:0]        m_r_data
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(TIMEOUT);
  state_t state;
  logic [IW-1:0] idx, ptr, pick;
  logic [CW-1:0] cnt;
  logic wr, any;
  logic [NREQ-1:0] onehot;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];
  logic [STRB_W-1:0] strb_a [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_wdata[i*DATA_W +: DATA_W];
    assign strb_a[i] = req_wstrb[i*STRB_W +: STRB_W];
  end
  assign m_aw_addr = addr;
  assign m_ar_addr = addr;
  axi_master_arbiter_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req_valid), .ptr(ptr), .any(any), .idx(pick), .gnt(onehot)
  );
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state <= IDLE;
      idx <= '0;
      ptr <= '0;
      cnt <= '0;
      wr <= 1'b0;
      addr <= '0;
      m_w_data <= '0;
      m_w_strb <= '0;
      req_gnt <= '0;
      req_done <= '0;
      req_err <= 1'b0;
      req_rdata <= '0;
      m_valid <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_valid_r <= 1'b0;
      req_done <= '0;
      case (state)
        IDLE: if (any) begin
          idx <= pick;
          wr <= req_write[pick];
          addr <= addr_a[pick];
          m_w_data <= data_a[pick];
          m_w_strb <= strb_a[pick];
          req_gnt <= onehot;
          m_valid <= req_write[pick];
          m_valid_r <= !req_write[pick];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (wr ? m_ready : m_r_done) begin
          req_done <= req_gnt;
          req_err <= 1'b0;
          req_rdata <= wr ? req_rdata : m_r_data;
          state <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          req_done <= req_gnt;
          req_err <= 1'b1;
          req_rdata <= '0;
          state <= DONE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          ptr <= idx == IW'(NREQ - 1) ? '0 : idx + IW'(1);
          req_gnt <= '0;
          req_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb_axi_master_arbiter: scoreboard bench driving requesters and a scripted master
module tb_axi_master_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  logic ACLK, ARESET;
  logic [NREQ-1:0] req_valid, req_write, req_gnt, req_done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*SW-1:0] req_wstrb;
  logic req_err, m_valid, m_valid_r, m_ready, m_r_done;
  logic [DW-1:0] req_rdata, m_w_data, m_r_data;
  logic [AW-1:0] m_aw_addr, m_ar_addr;
  logic [SW-1:0] m_w_strb;
  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] w [NREQ];
  logic [SW-1:0] s [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a[g];
    assign req_wdata[g*DW +: DW] = w[g];
    assign req_wstrb[g*SW +: SW] = s[g];
  end
  axi_master_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .m_valid(m_valid), .m_valid_r(m_valid_r), .m_aw_addr(m_aw_addr), .m_ar_addr(m_ar_addr),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_ready(m_ready), .m_r_done(m_r_done),
    .m_r_data(m_r_data)
  );
  typedef struct {int idx; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb;} iss_t;
  typedef struct {int idx; logic err; logic chk_rd; logic [DW-1:0] rd; logic [AW-1:0] addr; int lat;} dn_t;
  iss_t iq[$];
  dn_t dq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, issue_cyc = 0, issue_cnt = 0, done_cnt = 0, exp_ptr = 0;
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge ACLK);
    #1;
  endtask
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int o = 0; o < NREQ; o++)
      if (r[(p + o) % NREQ]) return (p + o) % NREQ;
    return -1;
  endfunction
  always @(negedge ACLK) begin : mon
    iss_t e;
    dn_t d;
    if (m_valid || m_valid_r) begin
      if (iq.size() == 0) check("issue_unexpected", 1, 0);
      else begin
        e = iq.pop_front();
        check("issue_m_valid", m_valid, e.wr);
        check("issue_m_valid_r", m_valid_r, !e.wr);
        check("issue_gnt", req_gnt, 64'(1) << e.idx);
        check("issue_aw_addr", m_aw_addr, e.addr);
        check("issue_ar_addr", m_ar_addr, e.addr);
        if (e.wr) begin
          check("issue_wdata", m_w_data, e.data);
          check("issue_wstrb", m_w_strb, e.strb);
        end
      end
      issue_cyc = cyc;
      issue_cnt++;
    end
    if (|req_done) begin
      if (dq.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = dq.pop_front();
        check("done_vec", req_done, 64'(1) << d.idx);
        check("done_gnt", req_gnt, 64'(1) << d.idx);
        check("done_err", req_err, d.err);
        check("done_addr_held", m_aw_addr, d.addr);
        check("done_latency", cyc - issue_cyc, d.lat);
        if (d.chk_rd) check("done_rdata", req_rdata, d.rd);
      end
      done_cnt++;
    end
  end
  task automatic start_txn(output int k);
    iss_t ie;
    int n0, n;
    k = rr_pick(req_valid, exp_ptr);
    ie.idx = k;
    ie.wr = req_write[k];
    ie.addr = a[k];
    ie.data = w[k];
    ie.strb = s[k];
    iq.push_back(ie);
    n0 = issue_cnt;
    n = 0;
    while (issue_cnt == n0 && n < 20) begin
      tick;
      n++;
    end
    check("issue_seen", issue_cnt, n0 + 1);
  endtask
  // kind: 0 proper completion after d cycles, 1 no completion (timeout), 2 stray wrong-direction pulse first
  task automatic do_txn(input int kind, input int d, input logic [DW-1:0] rd);
    dn_t de;
    int k, n0, n;
    logic wr;
    start_txn(k);
    wr = req_write[k];
    de.idx = k;
    de.err = kind == 1;
    de.chk_rd = !wr;
    de.rd = kind == 1 ? '0 : rd;
    de.addr = a[k];
    de.lat = kind == 1 ? TO + 1 : d + 1;
    dq.push_back(de);
    req_valid[k] = 1'b0;
    a[k] = ~a[k];
    w[k] = ~w[k];
    n0 = done_cnt;
    for (int t = 1; t <= d && kind != 1; t++) begin
      tick;
      m_ready = (kind == 2 && t == 1 && !wr) || (t == d && wr);
      m_r_done = (kind == 2 && t == 1 && wr) || (t == d && !wr);
      m_r_data = t == d ? rd : 32'hBAD0BAD0;
    end
    tick;
    m_ready = 1'b0;
    m_r_done = 1'b0;
    n = 0;
    while (done_cnt == n0 && n < TO + 10) begin
      tick;
      n++;
    end
    check("done_seen", done_cnt, n0 + 1);
    exp_ptr = (k + 1) % NREQ;
  endtask
  task automatic chk_zero(input string t);
    check({t, "_gnt"}, req_gnt, 0);
    check({t, "_done"}, req_done, 0);
    check({t, "_err"}, req_err, 0);
    check({t, "_rdata"}, req_rdata, 0);
    check({t, "_m_valid"}, m_valid, 0);
    check({t, "_m_valid_r"}, m_valid_r, 0);
    check({t, "_aw_addr"}, m_aw_addr, 0);
    check({t, "_w_data"}, m_w_data, 0);
    check({t, "_w_strb"}, m_w_strb, 0);
  endtask
  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] dt, input logic [SW-1:0] st);
    req_write[i] = wr;
    a[i] = ad;
    w[i] = dt;
    s[i] = st;
  endtask
  initial begin
    int k, n0;
    ARESET = 1'b0;
    req_valid = '0;
    req_write = '0;
    m_ready = 1'b0;
    m_r_done = 1'b0;
    m_r_data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0, '0);
    tick;
    tick;
    chk_zero("reset");
    ARESET = 1'b1;
    tick;
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req_valid = 3'b001;
    do_txn(0, 3, '0);
    set_req(0, 1'b0, 32'h100, '0, '0);
    set_req(1, 1'b0, 32'h200, '0, '0);
    for (int r = 0; r < 2; r++) begin
      req_valid = 3'b011;
      do_txn(0, 2, $urandom);
      do_txn(0, 1, $urandom);
    end
    set_req(1, 1'b0, 32'h300, '0, '0);
    req_valid = 3'b010;
    do_txn(0, 2, 32'h12345678);
    set_req(0, 1'b1, 32'h400, 32'h55AA55AA, 4'h3);
    req_valid = 3'b001;
    do_txn(1, 0, '0);
    set_req(0, 1'b0, 32'h500, '0, '0);
    set_req(1, 1'b1, 32'h600, 32'h01020304, 4'hC);
    set_req(2, 1'b0, 32'h700, '0, '0);
    req_valid = 3'b111;
    do_txn(1, 0, '0);
    do_txn(0, TO, 32'hA5A5A5A5);
    do_txn(0, 5, 32'h0F0F0F0F);
    set_req(2, 1'b0, 32'h800, '0, '0);
    req_valid = 3'b100;
    do_txn(2, 4, 32'hCAFEF00D);
    set_req(1, 1'b1, 32'h900, 32'h11112222, 4'h1);
    req_valid = 3'b010;
    do_txn(2, 3, '0);
    set_req(2, 1'b1, 32'hA00, 32'h33334444, 4'h5);
    req_valid = 3'b100;
    start_txn(k);
    req_valid = '0;
    tick;
    tick;
    ARESET = 1'b0;
    #1;
    chk_zero("mid_reset");
    n0 = done_cnt;
    tick;
    ARESET = 1'b1;
    exp_ptr = 0;
    tick;
    tick;
    check("no_done_after_reset", done_cnt, n0);
    set_req(1, 1'b0, 32'hB00, '0, '0);
    req_valid = 3'b010;
    do_txn(0, 2, 32'h87654321);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
      req_valid = req_valid | 3'($urandom_range(1, 7));
      do_txn(0, $urandom_range(1, TO), $urandom);
    end
    check("queues_drained", iq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
